regset_wb_ctrl: RTL and testbench
=================================

# regset_wb_ctrl

Write-back controller for the 32 x 32-bit register set.
- Arbitrates the single register-set write port between the execute unit (requester 0) and the load unit (requester 1), using round-robin.
- Registers the winning write onto the register-set `D`/`A_D`/`write_enable` inputs.
- Keeps a 32-entry busy scoreboard so decode can stall on a source register that has a write still in flight.
- Sits between the execute/memory stages and the register set; one instance per core.

## Interface
- `XLEN`, 32, data width of the write-back bus.
- `CLK` input 1 — single clock, all state on rising edge.
- `RES` input 1 — reset; one clock, reset is synchronous and active-high.
- `req0_valid` input 1 — execute unit has a write-back.
- `req0_rd` input 5 — destination register of req0.
- `req0_data` input XLEN — result of req0.
- `req0_ready` output 1 — req0 granted this cycle.
- `req1_valid`, `req1_rd`, `req1_data`, `req1_ready` — same as above for the load unit.
- `res_valid` input 1 — decode issues an instruction with a destination.
- `res_rd` input 5 — destination register being reserved.
- `chk_a0`, `chk_a1` input 5 each — source addresses being decoded.
- `busy_q0`, `busy_q1` output 1 each — matching source has a pending write.
- `busy_cnt` output 6 — number of busy registers (0..31).
- `D` output XLEN — write data to the register set.
- `A_D` output 5 — write address to the register set.
- `write_enable` output 1 — write strobe to the register set.

## Operation
- **Handshake**
  - A transfer occurs on a rising edge where `reqN_valid & reqN_ready`.
  - `reqN_ready` is combinational from the valids and the arbitration pointer.
  - At most one ready is high per cycle.
  - A requester holds valid, rd and data stable until its transfer.
- **Arbitration**
  - Only one valid: it is granted.
  - Both valid: grant the requester that did not win the last grant.
  - One-bit pointer `last` updates on every transfer; reset value is 1, so requester 0 wins the first tie.
  - Neither valid: no grant, pointer unchanged.
- **Output stage**
  - On a transfer, `D`/`A_D` load the granted data/rd on that edge.
  - `write_enable` <= 1 on a transfer with rd != 0, otherwise 0.
  - An rd = 0 request is consumed and granted normally but produces no write.
  - With no transfer, `write_enable` <= 0; `D`/`A_D` hold their previous values.
- **Scoreboard**
  - `busy[31:1]`; register 0 is never busy.
  - Set: `res_valid & res_rd != 0` sets `busy[res_rd]` on the edge.
  - Clear: `write_enable` high clears `busy[A_D]` on the same edge the register set commits the data.
  - Set and clear of the same index on one edge: set wins, because a new producer is now in flight.
  - Setting an already-busy index leaves it busy; the scoreboard does not count.
  - `busy_qN` = `busy[chk_aN]`, combinational; 0 when `chk_aN` = 0.
  - `busy_cnt` is a registered popcount, updated with `busy`: +1 per new set, −1 per effective clear, both on one edge as a net change.
- **Reset**
  - `RES` high forces `req0_ready` = `req1_ready` = 0 combinationally; reserve and check inputs are ignored.
  - Next edge: `D` = 0, `A_D` = 0, `write_enable` = 0, `busy` = 0, `busy_cnt` = 0, `last` = 1.
  - Reset mid-transfer drops any in-flight write; the requester sees no ready and must re-present its request after reset.

## Timing
- Request to `write_enable` high: 1 cycle (edge of transfer).
- Register-set commit: edge after `write_enable` rises.
- `busy` clear: also the edge after `write_enable` rises, so a source read in the cycle `busy_q` first reads 0 sees the committed value.
- Reserve to `busy_q` high: 1 cycle.
- Sustained throughput: one write per cycle.
- Under continuous contention each requester gets every other cycle.

## Test plan
- Reset, then idle 3 cycles -> `write_enable` = 0, `A_D` = 0, `D` = 0, `busy_cnt` = 0, both readys 0 while RES is high.
- req0 (rd = 3, data = 0xDEADBEEF) alone -> `req0_ready` = 1 that cycle; next cycle `write_enable` = 1, `A_D` = 3, `D` = 0xDEADBEEF.
- Contention:
  - Stimulus: both valid for 4 cycles; req0 rd = 1, data = 0x11; req1 rd = 2, data = 0x22.
  - Required: grants alternate 0, 1, 0, 1; `A_D` sequence 1, 2, 1, 2, one cycle delayed.
- Scoreboard round trip:
  - Stimulus: reserve rd = 7; `chk_a0` = 7; then write-back to 7.
  - Required: `busy_q0` = 1 from the next cycle; `busy_cnt` = 1; `busy_q0` returns to 0 and `busy_cnt` to 0 on the edge where `write_enable` = 1 with `A_D` = 7.
- Same-edge set/clear on rd = 9 -> `busy[9]` stays 1, `busy_cnt` unchanged.
- rd = 0 handling:
  - Reserve with rd = 0 -> `busy_cnt` stays 0.
  - req1 with rd = 0 -> `req1_ready` = 1, next cycle `write_enable` = 0.
- Reset while both requesters are valid and busy = 3 -> readys 0, everything cleared next edge, `last` = 1.

Source files
------------

// File: rtl/regset_wb_ctrl.sv
// Write-back controller: round-robin arbitration of the register-set write port
// between execute (req0) and load (req1), plus a busy scoreboard for decode stalls.
module regset_wb_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RES,
  input  logic            req0_valid,
  input  logic [4:0]      req0_rd,
  input  logic [XLEN-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [4:0]      req1_rd,
  input  logic [XLEN-1:0] req1_data,
  output logic            req1_ready,
  input  logic            res_valid,
  input  logic [4:0]      res_rd,
  input  logic [4:0]      chk_a0,
  input  logic [4:0]      chk_a1,
  output logic            busy_q0,
  output logic            busy_q1,
  output logic [5:0]      busy_cnt,
  output logic [XLEN-1:0] D,
  output logic [4:0]      A_D,
  output logic            write_enable
);

  logic            last;
  logic            xfer;
  logic [4:0]      win_rd;
  logic [XLEN-1:0] win_data;
  logic [31:1]     busy;
  logic [31:1]     set_vec;
  logic [31:1]     clr_vec;
  logic [31:1]     busy_nxt;
  logic [5:0]      cnt_nxt;
  logic [31:0]     busy_full;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!RES) begin
      req0_ready = req0_valid & (~req1_valid | last);
      req1_ready = req1_valid & (~req0_valid | ~last);
    end
    xfer     = req0_ready | req1_ready;
    win_rd   = req1_ready ? req1_rd   : req0_rd;
    win_data = req1_ready ? req1_data : req0_data;
  end

  // Set beats clear on the same index: a newer producer is already in flight.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int i = 1; i < 32; i++) begin
      if (res_valid && res_rd == 5'(i))
        set_vec[i] = 1'b1;
      if (write_enable && A_D == 5'(i))
        clr_vec[i] = 1'b1;
    end
    busy_nxt = (busy & ~clr_vec) | set_vec;
    cnt_nxt  = '0;
    for (int i = 1; i < 32; i++)
      cnt_nxt = cnt_nxt + 6'(busy_nxt[i]);
  end

  assign busy_full = {busy, 1'b0};
  assign busy_q0   = ~RES & busy_full[chk_a0];
  assign busy_q1   = ~RES & busy_full[chk_a1];

  always_ff @(posedge CLK) begin
    if (RES) begin
      last         <= 1'b1;
      D            <= '0;
      A_D          <= '0;
      write_enable <= 1'b0;
      busy         <= '0;
      busy_cnt     <= '0;
    end else begin
      if (req0_ready)
        last <= 1'b0;
      else if (req1_ready)
        last <= 1'b1;
      // rd = 0 transfers still load D/A_D but never strobe the register set.
      if (xfer) begin
        D   <= win_data;
        A_D <= win_rd;
      end
      write_enable <= xfer && (win_rd != 5'd0);
      busy         <= busy_nxt;
      busy_cnt     <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_regset_wb_ctrl.sv
// Self-checking bench for regset_wb_ctrl: table of per-cycle vectors with
// hand-written expectations, and a queue of expected register-set writes.
module tb_regset_wb_ctrl;

  localparam int XLEN = 32;

  logic            CLK = 1'b0;
  logic            RES;
  logic            req0_valid, req1_valid, req0_ready, req1_ready;
  logic [4:0]      req0_rd, req1_rd, res_rd, chk_a0, chk_a1, A_D;
  logic [XLEN-1:0] req0_data, req1_data, D;
  logic            res_valid, busy_q0, busy_q1, write_enable;
  logic [5:0]      busy_cnt;

  regset_wb_ctrl #(.XLEN(XLEN)) dut (
    .CLK(CLK), .RES(RES),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_rd(res_rd), .chk_a0(chk_a0), .chk_a1(chk_a1),
    .busy_q0(busy_q0), .busy_q1(busy_q1), .busy_cnt(busy_cnt),
    .D(D), .A_D(A_D), .write_enable(write_enable)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        v0;  logic [4:0] rd0; logic [31:0] d0;
    logic        v1;  logic [4:0] rd1; logic [31:0] d1;
    logic        rv;  logic [4:0] rrd;
    logic [4:0]  c0;  logic [4:0] c1;
    logic        er0; logic       er1;
    logic        eb0; logic       eb1;
    logic [5:0]  ecnt;
  } vec_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  ad;
    logic [31:0] d;
  } wr_t;

  vec_t vecs[$];
  wr_t  exp_q[$];
  int   total  = 0;
  int   passed = 0;
  logic [4:0]  hold_ad = '0;
  logic [31:0] hold_d  = '0;

  function automatic vec_t mk(input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                              input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
                              input logic rv, input logic [4:0] rrd,
                              input logic [4:0] c0, input logic [4:0] c1,
                              input logic er0, input logic er1,
                              input logic eb0, input logic eb1, input logic [5:0] ecnt);
    return '{v0, rd0, d0, v1, rd1, d1, rv, rrd, c0, c1, er0, er1, eb0, eb1, ecnt};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    else
      passed++;
  endtask

  task automatic applyStimulus(input vec_t v);
    req0_valid = v.v0; req0_rd = v.rd0; req0_data = v.d0;
    req1_valid = v.v1; req1_rd = v.rd1; req1_data = v.d1;
    res_valid  = v.rv; res_rd  = v.rrd;
    chk_a0     = v.c0; chk_a1  = v.c1;
  endtask

  task automatic popWrite(input int row);
    wr_t e;
    if (exp_q.size() == 0) begin
      checkOutput("queue_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      checkOutput($sformatf("row%0d write_enable", row), 32'(write_enable), 32'(e.we));
      checkOutput($sformatf("row%0d A_D", row), 32'(A_D), 32'(e.ad));
      checkOutput($sformatf("row%0d D", row), D, e.d);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t idle;
    wr_t  e;
    idle = mk(0,0,0, 0,0,0, 0,0, 0,0, 0,0, 0,0, 0);
    applyStimulus(idle);

    // Reset with a requester valid: readys must stay low.
    RES = 1'b1;
    req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'h1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #4;
      checkOutput($sformatf("reset%0d req0_ready", i), 32'(req0_ready), 32'd0);
      checkOutput($sformatf("reset%0d req1_ready", i), 32'(req1_ready), 32'd0);
    end
    checkOutput("reset write_enable", 32'(write_enable), 32'd0);
    checkOutput("reset A_D", 32'(A_D), 32'd0);
    checkOutput("reset D", D, 32'd0);
    checkOutput("reset busy_cnt", 32'(busy_cnt), 32'd0);
    applyStimulus(idle);
    RES = 1'b0;

    //               v0 rd0 d0            v1 rd1 d1      rv rrd c0 c1 er0 er1 eb0 eb1 cnt
    vecs.push_back(mk(1, 3, 32'hDEADBEEF, 0, 0, 0,       0, 0,  0, 0, 1, 0, 0, 0, 0)); // R0 lone req0
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       0, 0,  0, 0, 0, 0, 0, 0, 0)); // R1 idle
    vecs.push_back(mk(0, 0, 0,            1, 0, 32'h55,  0, 0,  0, 0, 0, 1, 0, 0, 0)); // R2 req1 rd0
    vecs.push_back(mk(1, 1, 32'h11,       1, 2, 32'h22,  0, 0,  0, 0, 1, 0, 0, 0, 0)); // R3 contention
    vecs.push_back(mk(1, 1, 32'h11,       1, 2, 32'h22,  0, 0,  0, 0, 0, 1, 0, 0, 0)); // R4
    vecs.push_back(mk(1, 1, 32'h11,       1, 2, 32'h22,  0, 0,  0, 0, 1, 0, 0, 0, 0)); // R5
    vecs.push_back(mk(1, 1, 32'h11,       1, 2, 32'h22,  0, 0,  0, 0, 0, 1, 0, 0, 0)); // R6
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       1, 7,  7, 0, 0, 0, 0, 0, 0)); // R7 reserve 7
    vecs.push_back(mk(1, 7, 32'h77,       0, 0, 0,       0, 0,  7, 0, 1, 0, 1, 0, 1)); // R8 write 7
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       0, 0,  7, 0, 0, 0, 1, 0, 1)); // R9 we=1 A_D=7
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       0, 0,  7, 0, 0, 0, 0, 0, 0)); // R10 cleared
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       1, 0,  0, 0, 0, 0, 0, 0, 0)); // R11 reserve rd0
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       1, 9,  0, 9, 0, 0, 0, 0, 0)); // R12 reserve 9
    vecs.push_back(mk(0, 0, 0,            1, 9, 32'h99,  0, 0,  0, 9, 0, 1, 0, 1, 1)); // R13 write 9
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       1, 9,  0, 9, 0, 0, 0, 1, 1)); // R14 set+clear 9
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       1, 0,  0, 9, 0, 0, 0, 1, 1)); // R15 still busy
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       1, 4,  9, 4, 0, 0, 1, 0, 1)); // R16 reserve 4
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       1, 5,  4, 5, 0, 0, 1, 0, 2)); // R17 reserve 5
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       1, 9,  5, 9, 0, 0, 1, 1, 3)); // R18 re-reserve 9
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       0, 0,  9, 5, 0, 0, 1, 1, 3)); // R19
    vecs.push_back(mk(1, 10, 32'hA0A0,    0, 0, 0,       0, 0,  0, 0, 1, 0, 0, 0, 3)); // R20 last -> 0
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       0, 0,  9, 4, 0, 0, 1, 1, 3)); // R21

    foreach (vecs[r]) begin
      @(posedge CLK); #1;
      if (r > 0) popWrite(r - 1);
      applyStimulus(vecs[r]);
      #3;
      checkOutput($sformatf("row%0d req0_ready", r), 32'(req0_ready), 32'(vecs[r].er0));
      checkOutput($sformatf("row%0d req1_ready", r), 32'(req1_ready), 32'(vecs[r].er1));
      checkOutput($sformatf("row%0d busy_q0", r), 32'(busy_q0), 32'(vecs[r].eb0));
      checkOutput($sformatf("row%0d busy_q1", r), 32'(busy_q1), 32'(vecs[r].eb1));
      checkOutput($sformatf("row%0d busy_cnt", r), 32'(busy_cnt), 32'(vecs[r].ecnt));
      if (vecs[r].er0) begin
        hold_ad = vecs[r].rd0; hold_d = vecs[r].d0;
        e = '{(vecs[r].rd0 != 5'd0), hold_ad, hold_d};
      end else if (vecs[r].er1) begin
        hold_ad = vecs[r].rd1; hold_d = vecs[r].d1;
        e = '{(vecs[r].rd1 != 5'd0), hold_ad, hold_d};
      end else begin
        e = '{1'b0, hold_ad, hold_d};
      end
      exp_q.push_back(e);
    end
    @(posedge CLK); #1;
    popWrite(vecs.size() - 1);

    // Reset with both requesters valid, three registers busy, pointer at 0.
    applyStimulus(mk(1, 1, 32'h11, 1, 2, 32'h22, 1, 6, 6, 9, 0, 0, 0, 0, 0));
    RES = 1'b1;
    #3;
    checkOutput("midreset req0_ready", 32'(req0_ready), 32'd0);
    checkOutput("midreset req1_ready", 32'(req1_ready), 32'd0);
    @(posedge CLK); #1;
    checkOutput("midreset write_enable", 32'(write_enable), 32'd0);
    checkOutput("midreset A_D", 32'(A_D), 32'd0);
    checkOutput("midreset D", D, 32'd0);
    checkOutput("midreset busy_cnt", 32'(busy_cnt), 32'd0);
    RES = 1'b0;
    res_valid = 1'b0;
    #3;
    checkOutput("postreset busy_q0", 32'(busy_q0), 32'd0);
    checkOutput("postreset busy_q1", 32'(busy_q1), 32'd0);
    checkOutput("postreset req0_ready", 32'(req0_ready), 32'd1);
    checkOutput("postreset req1_ready", 32'(req1_ready), 32'd0);
    @(posedge CLK); #1;
    checkOutput("postreset write_enable", 32'(write_enable), 32'd1);
    checkOutput("postreset A_D", 32'(A_D), 32'd1);
    checkOutput("postreset D", D, 32'h11);
    applyStimulus(idle);
    repeat (2) @(posedge CLK);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
